// File: rtl/elevator_car_ctrl.sv
// Per-car elevator motion controller: latches floor requests, serves them in
// SCAN order, and times floor-to-floor travel and door dwell from a prescaled tick.
module elevator_car_ctrl #(
  parameter int unsigned FLOORS       = 4,
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned TRAVEL_TICKS = 2,
  parameter int unsigned DOOR_TICKS   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] req,
  output logic [FLOORS-1:0] floor_onehot,
  output logic [FLOORS-1:0] pending,
  output logic              moving,
  output logic              dir_up,
  output logic              door_open
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMAX    = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int unsigned TICK_W  = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TRAVEL_LAST = TICK_W'(TRAVEL_TICKS - 1);
  localparam logic [TICK_W-1:0]  DOOR_LAST   = TICK_W'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } state_t;

  state_t              r_state;
  logic [FLOORS-1:0]   r_floor;
  logic [FLOORS-1:0]   r_pending;
  logic                r_dir_up;
  logic                r_moving;
  logic                r_door_open;
  logic [PRESC_W-1:0]  r_presc;
  logic [TICK_W-1:0]   r_ticks;

  state_t              w_state_nxt;
  logic [FLOORS-1:0]   w_floor_nxt;
  logic [FLOORS-1:0]   w_pending_nxt;
  logic                w_dir_nxt;
  logic                w_clr;

  logic [FLOORS-1:0]   w_eff;
  logic [FLOORS-1:0]   w_above_mask;
  logic [FLOORS-1:0]   w_below_mask;
  logic                w_any_above;
  logic                w_any_below;
  logic                w_tick;
  logic [FLOORS-1:0]   w_up_floor;
  logic [FLOORS-1:0]   w_dn_floor;
  logic                w_up_ahead;
  logic                w_dn_ahead;

  // Request view and direction masks derived from the one-hot floor word
  always_comb begin
    w_eff        = r_pending | req;
    w_below_mask = r_floor - FLOORS'(1);
    w_above_mask = ~(r_floor | w_below_mask);
    w_any_above  = |(w_eff & w_above_mask);
    w_any_below  = |(w_eff & w_below_mask);
    w_tick       = (r_presc == PRESC_LAST);
    // Shift with saturation at the end floors
    w_up_floor   = r_floor[FLOORS-1] ? r_floor : (r_floor << 1);
    w_dn_floor   = r_floor[0]        ? r_floor : (r_floor >> 1);
    w_up_ahead   = |(w_eff & ~(w_up_floor | (w_up_floor - FLOORS'(1))));
    w_dn_ahead   = |(w_eff & (w_dn_floor - FLOORS'(1)));
  end

  // Next-state, next-floor, pending and timer-clear decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_floor_nxt   = r_floor;
    w_pending_nxt = w_eff;
    w_dir_nxt     = r_dir_up;
    w_clr         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clr = 1'b1;
        if (|(w_eff & r_floor)) begin
          w_state_nxt   = S_DOOR;
          w_pending_nxt = w_eff & ~r_floor;
        end else if (w_any_above && (r_dir_up || !w_any_below)) begin
          w_state_nxt = S_MOVE_UP;
          w_dir_nxt   = 1'b1;
        end else if (w_any_below) begin
          w_state_nxt = S_MOVE_DOWN;
          w_dir_nxt   = 1'b0;
        end
      end
      S_MOVE_UP: begin
        if (w_tick && (r_ticks == TRAVEL_LAST)) begin
          w_floor_nxt = w_up_floor;
          w_clr       = 1'b1;
          if (|(w_eff & w_up_floor)) begin
            w_state_nxt   = S_DOOR;
            w_pending_nxt = w_eff & ~w_up_floor;
          end else if (!w_up_ahead) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_MOVE_DOWN: begin
        if (w_tick && (r_ticks == TRAVEL_LAST)) begin
          w_floor_nxt = w_dn_floor;
          w_clr       = 1'b1;
          if (|(w_eff & w_dn_floor)) begin
            w_state_nxt   = S_DOOR;
            w_pending_nxt = w_eff & ~w_dn_floor;
          end else if (!w_dn_ahead) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        // A call for this floor during dwell holds the door rather than queueing
        w_pending_nxt = w_eff & ~r_floor;
        if (|(req & r_floor)) begin
          w_clr = 1'b1;
        end else if (w_tick && (r_ticks == DOOR_LAST)) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_clr       = 1'b1;
      end
    endcase
  end

  // State, floor, request and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_floor     <= FLOORS'(1);
      r_pending   <= '0;
      r_dir_up    <= 1'b1;
      r_moving    <= 1'b0;
      r_door_open <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_floor     <= w_floor_nxt;
      r_pending   <= w_pending_nxt;
      r_dir_up    <= w_dir_nxt;
      r_moving    <= (w_state_nxt == S_MOVE_UP) || (w_state_nxt == S_MOVE_DOWN);
      r_door_open <= (w_state_nxt == S_DOOR);
    end
  end

  // Prescaler and tick counter, restarted on every state entry and dwell hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_ticks <= '0;
    end else if (w_clr) begin
      r_presc <= '0;
      r_ticks <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_ticks <= r_ticks + TICK_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign floor_onehot = r_floor;
  assign pending      = r_pending;
  assign moving       = r_moving;
  assign dir_up       = r_dir_up;
  assign door_open    = r_door_open;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: directed scenarios plus random request traffic,
// every cycle compared against a cycle-countdown model of the car.
module tb_elevator_car_ctrl;

  localparam int unsigned FLOORS       = 4;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned TRAVEL_TICKS = 2;
  localparam int unsigned DOOR_TICKS   = 3;
  localparam int TRAV_C = TRAVEL_TICKS * TICK_DIV;
  localparam int DOOR_C = DOOR_TICKS * TICK_DIV;
  localparam int BOUND  = 300;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [FLOORS-1:0] req;
  logic [FLOORS-1:0] floor_onehot;
  logic [FLOORS-1:0] pending;
  logic              moving;
  logic              dir_up;
  logic              door_open;

  elevator_car_ctrl #(
    .FLOORS      (FLOORS),
    .TICK_DIV    (TICK_DIV),
    .TRAVEL_TICKS(TRAVEL_TICKS),
    .DOOR_TICKS  (DOOR_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .floor_onehot(floor_onehot),
    .pending     (pending),
    .moving      (moving),
    .dir_up      (dir_up),
    .door_open   (door_open)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: floor index, request set, mode (0 idle, 1 travel, 2 dwell), direction,
  // cycles remaining in the current travel leg or dwell.
  int          m_f;
  logic [3:0]  m_pend;
  int          m_mode;
  bit          m_up;
  int          m_rem;

  function automatic bit any_above(input logic [3:0] v, input int f);
    for (int i = f + 1; i < 4; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input logic [3:0] v, input int f);
    for (int i = 0; i < f; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_f = 0; m_pend = '0; m_mode = 0; m_up = 1'b1; m_rem = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] eff;
    eff = m_pend | r;
    case (m_mode)
      0: begin
        m_pend = eff;
        if (eff[m_f]) begin
          m_mode = 2; m_rem = DOOR_C; m_pend[m_f] = 1'b0;
        end else if (any_above(eff, m_f) && (m_up || !any_below(eff, m_f))) begin
          m_mode = 1; m_up = 1'b1; m_rem = TRAV_C;
        end else if (any_below(eff, m_f)) begin
          m_mode = 1; m_up = 1'b0; m_rem = TRAV_C;
        end
      end
      1: begin
        m_pend = eff;
        if (m_rem > 1) begin
          m_rem--;
        end else begin
          if (m_up) m_f = (m_f < 3) ? m_f + 1 : 3;
          else      m_f = (m_f > 0) ? m_f - 1 : 0;
          if (eff[m_f]) begin
            m_mode = 2; m_rem = DOOR_C; m_pend[m_f] = 1'b0;
          end else if (m_up ? any_above(eff, m_f) : any_below(eff, m_f)) begin
            m_rem = TRAV_C;
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
        m_pend = eff;
        m_pend[m_f] = 1'b0;
        if (r[m_f])         m_rem = DOOR_C;
        else if (m_rem > 1) m_rem--;
        else                m_mode = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    chk("floor_onehot", 32'(floor_onehot), 32'(1) << m_f);
    chk("pending",      32'(pending),      32'(m_pend));
    chk("moving",       32'(moving),       32'(m_mode == 1));
    chk("door_open",    32'(door_open),    32'(m_mode == 2));
    chk("dir_up",       32'(dir_up),       32'(m_up));
    chk("move_door_excl", 32'(moving & door_open), 32'(0));
    chk("onehot_count", 32'($countones(floor_onehot)), 32'(1));
  endtask

  // One clock: drive req, let both DUT and model take the edge, compare mid-cycle
  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_to_idle(input string tag);
    int k;
    k = 0;
    while (!(m_mode == 0 && m_pend == 4'b0000) && k < BOUND) begin
      cycle(4'b0000);
      k++;
    end
    if (k >= BOUND) chk(tag, 32'(0), 32'(1));
    cycle(4'b0000);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_floor",   32'(floor_onehot), 32'(4'b0001));
    chk("rst_pending", 32'(pending),      32'(0));
    chk("rst_moving",  32'(moving),       32'(0));
    chk("rst_door",    32'(door_open),    32'(0));
    chk("rst_dir",     32'(dir_up),       32'(1));
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    int k;
    logic [3:0] r;
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Idle after reset
    repeat (100) cycle(4'b0000);

    // Single trip to the top floor, then back down
    cycle(4'b1000);
    run_to_idle("timeout_single_trip");
    cycle(4'b0001);
    run_to_idle("timeout_return");

    // SCAN: while heading up past floor 2 toward 4, call floors 1 and 3
    cycle(4'b1000);
    k = 0;
    while (!(m_mode == 1 && m_f == 1) && k < BOUND) begin cycle(4'b0000); k++; end
    if (k >= BOUND) chk("timeout_scan", 32'(0), 32'(1));
    cycle(4'b0101);
    run_to_idle("timeout_scan_idle");

    // Same-floor call, then a repeat call holding the door
    cycle(4'b0001);
    repeat (5) cycle(4'b0000);
    cycle(4'b0001);
    run_to_idle("timeout_same_floor");

    // Strobe for floor 3 exactly in the arrival cycle there while bound for 4
    cycle(4'b1000);
    k = 0;
    while (!(m_mode == 1 && m_up && m_f == 1 && m_rem == 1) && k < BOUND) begin
      cycle(4'b0000); k++;
    end
    if (k >= BOUND) chk("timeout_arrival", 32'(0), 32'(1));
    cycle(4'b0100);
    chk("arrival_stop_door", 32'(door_open), 32'(1));
    run_to_idle("timeout_arrival_idle");
    cycle(4'b0001);
    run_to_idle("timeout_arrival_return");

    // Reset while travelling between floors 2 and 3 with floor 4 pending
    cycle(4'b1000);
    k = 0;
    while (!(m_mode == 1 && m_f == 1) && k < BOUND) begin cycle(4'b0000); k++; end
    if (k >= BOUND) chk("timeout_rst_move", 32'(0), 32'(1));
    repeat (3) cycle(4'b0000);
    async_reset();

    // Random request traffic with occasional mid-operation reset
    for (int i = 0; i < 4000; i++) begin
      r = '0;
      if ($urandom_range(0, 11) == 0) r = 4'(1 << $urandom_range(0, 3));
      else if ($urandom_range(0, 63) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) async_reset();
      else cycle(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
